// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command port in, APB SETUP/ACCESS on the bus, one-cycle response pulse out.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_next;
  logic   accept;
  logic   complete;
  logic   abort;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  assign cmd_ready = (state == IDLE) || ((state == ACCESS) && pready);
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state == ACCESS) && pready;

  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign busy    = (state != IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts stalled ACCESS cycles; the abort fires on the cycle that would make it TIMEOUT_CYCLES.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign abort = (state == ACCESS) && !pready && (wait_cnt == CNT_LAST);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (complete) begin
          state_next = accept ? SETUP : IDLE;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus command registers hold their last value in IDLE; the response is a registered one-cycle pulse.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      rsp_valid <= complete || abort;
      rsp_rdata <= (complete && !pwrite) ? prdata : '0;
      rsp_err   <= complete ? pslverr : abort;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a vector table run through an APB completer model, plus
// hand-written back-to-back, reset-abort and stalled-slave sequences.
module tb_apb_master;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 8;

  logic                  pclk;
  logic                  preset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]      cmd_wdata;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [WIDTH-1:0]      pwdata;
  logic [WIDTH-1:0]      prdata;
  logic                  pready;
  logic                  pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .WIDTH(WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] slv_rdata;
    logic        slv_err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one command and plays a completer that inserts v.waits stall cycles; latency counts edges from accept to rsp_valid.
  task automatic apply_stimulus(input vec_t v);
    int  waits;
    int  lat;
    bit  got;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    check_output("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0BAD_0BAD;
    check_output("setup_psel_penable", {30'd0, psel, penable}, 32'd2);
    check_output("setup_paddr", {24'd0, paddr}, {24'd0, v.addr});
    check_output("setup_pwrite", {31'd0, pwrite}, {31'd0, v.write});
    if (v.write) check_output("setup_pwdata", pwdata, v.wdata);
    waits = v.waits;
    lat   = 0;
    got   = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (penable) begin
        check_output("access_paddr_stable", {24'd0, paddr}, {24'd0, v.addr});
        if (waits == 0) begin
          pready  = 1'b1;
          prdata  = v.slv_rdata;
          pslverr = v.slv_err;
        end else begin
          pready  = 1'b0;
          prdata  = 32'hFFFF_0000 ^ v.slv_rdata;
          pslverr = 1'b1;
          waits--;
        end
        #1;
        check_output("access_cmd_ready", {31'd0, cmd_ready}, {31'd0, pready});
      end else begin
        pready = 1'b0;
      end
      tick();
      lat++;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'hCAFE_F00D;
      got = rsp_valid;
    end
    check_output("rsp_seen", {31'd0, got}, 32'd1);
    check_output("rsp_latency", lat, v.exp_lat);
    check_output("rsp_rdata", rsp_rdata, v.exp_rdata);
    check_output("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    check_output("done_psel_busy", {30'd0, psel, busy}, 32'd0);
    tick();
    check_output("rsp_pulse_end", {30'd0, rsp_valid, rsp_err}, 32'd0);
  endtask

  initial begin
    int acc;
    vecs[0] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 2};
    vecs[1] = '{1'b0, 8'h10, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 5};
    vecs[2] = '{1'b0, 8'hFF, 32'h0000_0000, 0, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1, 2};
    vecs[3] = '{1'b0, 8'h20, 32'h0000_0000, 1, 32'h0000_1111, 1'b0, 32'h0000_1111, 1'b0, 3};
    vecs[4] = '{1'b1, 8'hFF, 32'h0000_0000, 2, 32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1, 4};
    vecs[5] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 0, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b0, 2};

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    tick();
    check_output("reset_ctrl", {26'd0, psel, penable, pwrite, rsp_valid, rsp_err, busy}, 32'd0);
    check_output("reset_paddr", {24'd0, paddr}, 32'd0);
    check_output("reset_pwdata", pwdata, 32'd0);
    check_output("reset_rsp_rdata", rsp_rdata, 32'd0);
    preset = 1'b0;
    tick();

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Back-to-back: write then read of 0x01 with cmd_valid held, no IDLE between transfers.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h01;
    cmd_wdata = 32'h0000_0001;
    tick();
    cmd_write = 1'b0;
    cmd_wdata = 32'h0;
    check_output("b2b_setup1", {30'd0, psel, penable}, 32'd2);
    check_output("b2b_setup_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    check_output("b2b_access1", {30'd0, psel, penable}, 32'd3);
    pready = 1'b1;
    #1;
    check_output("b2b_ready_complete", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    pready    = 1'b0;
    check_output("b2b_setup2", {29'd0, psel, penable, busy}, 32'd5);
    check_output("b2b_rsp1", {30'd0, rsp_valid, rsp_err}, 32'd2);
    check_output("b2b_rsp1_rdata", rsp_rdata, 32'd0);
    check_output("b2b_pwrite2", {31'd0, pwrite}, 32'd0);
    tick();
    check_output("b2b_access2", {29'd0, psel, penable, rsp_valid}, 32'd6);
    pready = 1'b1;
    prdata = 32'h0000_0001;
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    check_output("b2b_rsp2", {29'd0, rsp_valid, rsp_err, psel}, 32'd4);
    check_output("b2b_rsp2_rdata", rsp_rdata, 32'h0000_0001);
    tick();

    // Reset asserted for two cycles in the middle of a stalled ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h33;
    cmd_wdata = 32'h3333_3333;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_output("rst_mid_in_access", {30'd0, psel, penable}, 32'd3);
    preset = 1'b1;
    tick();
    check_output("rst_mid_ctrl", {26'd0, psel, penable, pwrite, rsp_valid, rsp_err, busy}, 32'd0);
    check_output("rst_mid_paddr", {24'd0, paddr}, 32'd0);
    check_output("rst_mid_pwdata", pwdata, 32'd0);
    tick();
    preset = 1'b0;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check_output("rst_mid_no_rsp", {29'd0, rsp_valid, psel, busy}, 32'd0);

    // Completer that never raises pready.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h44;
    tick();
    cmd_valid = 1'b0;
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    acc = 1;
    for (int c = 0; c < 20; c++) begin
      check_output("to_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      if (!psel) break;
      acc++;
    end
    check_output("to_access_cycles", acc, 4);
    check_output("to_rsp", {29'd0, rsp_valid, rsp_err, penable}, 32'd6);
    check_output("to_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check_output("to_rsp_end", {30'd0, rsp_valid, busy}, 32'd0);
`else
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      if (psel && penable && !rsp_valid) acc++;
      tick();
    end
    check_output("stall_held_cycles", acc, 100);
    check_output("stall_still_access", {30'd0, psel, penable}, 32'd3);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    tick();
    check_output("stall_reset_release", {30'd0, psel, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester and the bus-side counterpart of the team's APB slave memory. Accepts read/write commands on a valid/ready port, runs the APB IDLE → SETUP → ACCESS sequence on the bus, and returns read data and error status as a one-cycle response pulse. It sits between the testbench/processor-side command source and any APB completer, including slaves with wait states.

## Interface
- WIDTH, 32: pwdata/prdata/cmd/rsp data width
- ADDR_WIDTH, 8: paddr width
- TIMEOUT_CYCLES, 16: ACCESS cycles with pready low before abort (only with APB_MASTER_TIMEOUT_EN); must be ≥1
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  WIDTH  read data (0 for writes)
- rsp_err  out  1  pslverr sampled at completion, or timeout
- busy  out  1  state != IDLE
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  WIDTH  APB write data
- prdata  in  WIDTH  APB read data
- pready  in  1  completer ready
- pslverr  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS. psel = (SETUP|ACCESS), penable = ACCESS, both registered state decodes.
- cmd_ready = (state==IDLE) | (state==ACCESS & pready) — combinational; permits back-to-back transfers.
- IDLE: accept → latch cmd_write/addr/wdata into pwrite/paddr/pwdata → SETUP. No accept → stay IDLE.
- SETUP → ACCESS unconditionally.
- ACCESS, pready=0: stay; all bus outputs held stable.
- ACCESS, pready=1: completion. If cmd_valid → latch new command, go to SETUP directly (no IDLE cycle); else → IDLE.
- Completion: next cycle rsp_valid=1 for exactly one cycle; rsp_rdata = prdata sampled at completion edge if read, else 0; rsp_err = pslverr sampled at completion edge.
- paddr/pwdata/pwrite retain last values in IDLE (not cleared).
- prdata/pslverr ignored outside ACCESS&pready.

## Timing
- Reset (preset=1 at edge): state=IDLE; psel, penable, pwrite=0; paddr, pwdata=0; rsp_valid, rsp_err=0; rsp_rdata=0; busy=0.
- Reset mid-transfer: bus released the following cycle, no rsp_valid for the aborted command.
- Accept at edge N: SETUP in cycle N+1, ACCESS N+2; with zero-wait slave, completion edge ends N+2, rsp_valid in cycle N+3.
- Each pready=0 ACCESS cycle adds one cycle to latency.
- Back-to-back: ACCESS of transfer k immediately followed by SETUP of k+1; throughput 2 cycles/transfer with zero-wait slave. rsp_valid for k coincides with SETUP of k+1.
- cmd_valid in SETUP, or in ACCESS with pready=0: cmd_ready=0, command held by source.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYCLES+1) bits) cleared on SETUP entry, increments each ACCESS cycle with pready=0. On the cycle count reaches TIMEOUT_CYCLES with pready still 0: abort → IDLE (psel/penable low next cycle), rsp_valid=1 with rsp_err=1, rsp_rdata=0; cmd_ready=0 on that abort cycle.
- Not defined: no counter; ACCESS waits indefinitely for pready.

## Test plan
- Reset: preset=1 two cycles mid-ACCESS -> all outputs 0 next cycle, no rsp_valid.
- Write 0xDEADBEEF @0x10, zero-wait slave -> psel N+1, penable N+2, pwdata stable; rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read @0x10 with slave holding pready low 3 cycles, prdata=0xDEADBEEF -> ACCESS lasts 4 cycles, rsp_valid N+6, rsp_rdata=0xDEADBEEF.
- Back-to-back write 0x01 then read @0x01, cmd_valid held -> no IDLE between, second SETUP same cycle as first rsp_valid.
- Read @0xFF, slave asserts pslverr with pready -> rsp_err=1 for that pulse only.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> abort after 4 ACCESS cycles, rsp_valid with rsp_err=1, psel=0 next cycle; without macro, psel/penable remain 1 for 100 cycles.
